// File: rtl/cic_sched_pkg.sv
// cic_sched_pkg: shared state type, default widths and helpers
// for the order-5 CIC interpolator sequencer.
package cic_sched_pkg;

    localparam int DEF_IBITS      = 20;
    localparam int DEF_PHASE_BITS = 32;
    localparam int DEF_UCNT_BITS  = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN_WAIT,
        S_FETCH
    } state_t;

    // Increment v, sticking at the all-ones value of a bits-wide count.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          bits
    );
        logic [31:0] m;
        m = (bits >= 32) ? 32'hFFFF_FFFF
                         : ((32'd1 << bits) - 32'd1);
        return (v >= m) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cic_phase_strobe.sv
// cic_phase_strobe: phase accumulator whose carry-out becomes a
// registered one-clock strobe; held cleared while run is low.
module cic_phase_strobe
    import cic_sched_pkg::*;
#(
    parameter int W = DEF_PHASE_BITS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         run,
    input  logic [W-1:0] inc,
    output logic         strobe
);

    logic [W-1:0] r_acc;
    logic         r_strobe;
    logic [W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, inc};

    // Accumulate while running; carry-out is the next strobe.
    always_ff @(posedge clock) begin
        if (reset || !run) begin
            r_acc    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_acc    <= w_sum[W-1:0];
            r_strobe <= w_sum[W];
        end
    end

    assign strobe = r_strobe;

endmodule

// File: rtl/cic_interp_sched.sv
// cic_interp_sched: input sequencer for the order-5 CIC interpolator.
// Optional CIC_SCHED_ZERO_FILL_EN: zero the held sample on underflow.
module cic_interp_sched
    import cic_sched_pkg::*;
#(
    parameter int IBITS      = DEF_IBITS,
    parameter int PHASE_BITS = DEF_PHASE_BITS,
    parameter int UCNT_BITS  = DEF_UCNT_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PHASE_BITS-1:0] rate_inc,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IBITS-1:0]      s_real,
    input  logic [IBITS-1:0]      s_imag,
    output logic                  cic_clock_en,
    input  logic                  cic_req,
    output logic [IBITS-1:0]      cic_x_real,
    output logic [IBITS-1:0]      cic_x_imag,
    output logic                  underflow,
    output logic [UCNT_BITS-1:0]  underflow_cnt,
    output logic                  running
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IBITS-1:0]     r_x_real;
    logic [IBITS-1:0]     r_x_imag;
    logic                 r_uf;
    logic [UCNT_BITS-1:0] r_ucnt;
    logic [UCNT_BITS-1:0] w_ucnt_inc;
    logic                 w_ready;
    logic                 w_run;
    logic                 w_hs;
    logic                 w_uf;
    logic                 w_strobe;

    assign w_ready = (r_state == S_PRIME) || (r_state == S_FETCH);
    assign w_run   = (r_state == S_RUN_WAIT) || (r_state == S_FETCH);
    assign w_hs    = s_valid && w_ready;
    assign w_uf    = (r_state == S_FETCH) && cic_req && !w_hs;

    assign w_ucnt_inc = UCNT_BITS'(sat_inc(32'(r_ucnt), UCNT_BITS));

    // Gating run with enable stops the strobe on the disabling edge.
    cic_phase_strobe #(
        .W      (PHASE_BITS)
    ) u_strobe (
        .clock  (clock),
        .reset  (reset),
        .run    (w_run && enable),
        .inc    (rate_inc),
        .strobe (w_strobe)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; dropping enable returns to IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:     if (enable) w_state_nxt = S_PRIME;
            S_PRIME:    if (w_hs) w_state_nxt = S_RUN_WAIT;
            S_RUN_WAIT: if (cic_req) w_state_nxt = S_FETCH;
            S_FETCH:    if (w_hs && !cic_req) w_state_nxt = S_RUN_WAIT;
            default:    w_state_nxt = S_IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Holding registers: any accepted sample is kept, even on disable.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x_real <= '0;
            r_x_imag <= '0;
        end else if (w_hs) begin
            r_x_real <= s_real;
            r_x_imag <= s_imag;
`ifdef CIC_SCHED_ZERO_FILL_EN
        end else if (w_uf) begin
            r_x_real <= '0;
            r_x_imag <= '0;
`endif
        end
    end

    // Underflow pulse and saturating count; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_uf   <= 1'b0;
            r_ucnt <= '0;
        end else begin
            r_uf <= w_uf;
            if (w_uf) begin
                r_ucnt <= w_ucnt_inc;
            end
        end
    end

    assign s_ready       = w_ready;
    assign running       = w_run;
    assign cic_clock_en  = w_strobe;
    assign cic_x_real    = r_x_real;
    assign cic_x_imag    = r_x_imag;
    assign underflow     = r_uf;
    assign underflow_cnt = r_ucnt;

endmodule

// File: tb/tb_cic_interp_sched.sv
// tb_cic_interp_sched: directed checks of priming, rate, underflow,
// saturation, reset and disable behaviour of cic_interp_sched.
module tb_cic_interp_sched;

    localparam int IB = 20;
    localparam int PB = 32;
    localparam int UB = 2;

`ifdef CIC_SCHED_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          s_valid = 1'b0;
    logic          cic_req = 1'b0;
    logic [PB-1:0] rate_inc = '0;
    logic [IB-1:0] s_real = '0;
    logic [IB-1:0] s_imag = '0;
    logic          s_ready;
    logic          cic_clock_en;
    logic          underflow;
    logic          running;
    logic [IB-1:0] cic_x_real;
    logic [IB-1:0] cic_x_imag;
    logic [UB-1:0] underflow_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    cic_interp_sched #(
        .IBITS         (IB),
        .PHASE_BITS    (PB),
        .UCNT_BITS     (UB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .rate_inc      (rate_inc),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_real        (s_real),
        .s_imag        (s_imag),
        .cic_clock_en  (cic_clock_en),
        .cic_req       (cic_req),
        .cic_x_real    (cic_x_real),
        .cic_x_imag    (cic_x_imag),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt),
        .running       (running)
    );

    typedef struct {
        logic          en;
        logic          vld;
        logic [IB-1:0] re;
        logic [IB-1:0] im;
        logic          x_rdy;
        logic          x_ce;
        logic          x_run;
        logic [IB-1:0] x_re;
        logic [IB-1:0] x_im;
    } vec_t;

    vec_t tbl [18];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [IB-1:0] held;
        int            ce_cnt;
        int            uf_cnt;

        // Prime sequence: handshake on row 5, strobes every 4th clock.
        for (int i = 0; i < 18; i++) begin
            tbl[i].en    = 1'b1;
            tbl[i].vld   = (i == 5);
            tbl[i].re    = (i == 5) ? 20'h12345 : 20'h0;
            tbl[i].im    = (i == 5) ? 20'h54321 : 20'h0;
            tbl[i].x_rdy = (i <= 4);
            tbl[i].x_ce  = (i == 9) || (i == 13) || (i == 17);
            tbl[i].x_run = (i >= 5);
            tbl[i].x_re  = (i >= 5) ? 20'h12345 : 20'h0;
            tbl[i].x_im  = (i >= 5) ? 20'h54321 : 20'h0;
        end

        step();
        step();
        chk("rst s_ready", 64'(s_ready), 64'd0);
        chk("rst clock_en", 64'(cic_clock_en), 64'd0);
        chk("rst underflow", 64'(underflow), 64'd0);
        chk("rst ucnt", 64'(underflow_cnt), 64'd0);
        chk("rst running", 64'(running), 64'd0);
        chk("rst x_real", 64'(cic_x_real), 64'd0);
        chk("rst x_imag", 64'(cic_x_imag), 64'd0);

        reset    = 1'b0;
        rate_inc = 32'h4000_0000;
        for (int i = 0; i < 18; i++) begin
            enable  = tbl[i].en;
            s_valid = tbl[i].vld;
            s_real  = tbl[i].re;
            s_imag  = tbl[i].im;
            step();
            chk($sformatf("prime[%0d] s_ready", i),
                64'(s_ready), 64'(tbl[i].x_rdy));
            chk($sformatf("prime[%0d] clock_en", i),
                64'(cic_clock_en), 64'(tbl[i].x_ce));
            chk($sformatf("prime[%0d] running", i),
                64'(running), 64'(tbl[i].x_run));
            chk($sformatf("prime[%0d] x_real", i),
                64'(cic_x_real), 64'(tbl[i].x_re));
            chk($sformatf("prime[%0d] x_imag", i),
                64'(cic_x_imag), 64'(tbl[i].x_im));
        end

        // Rate: half rate for 7 clocks, then 1/8 from acc = 0x8000_0000.
        rate_inc = 32'h8000_0000;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk($sformatf("rate2[%0d]", i),
                64'(cic_clock_en), 64'((i % 2) == 0));
        end
        rate_inc = 32'h2000_0000;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("rate8[%0d]", i), 64'(cic_clock_en),
                64'((i == 4) || (i == 12) || (i == 20)));
        end
        rate_inc = 32'h0;
        ce_cnt   = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (cic_clock_en) ce_cnt++;
        end
        chk("rate0 strobes", 64'(ce_cnt), 64'd0);

        // Simultaneous request and handshake in FETCH.
        cic_req = 1'b1;
        step();
        chk("fetch s_ready", 64'(s_ready), 64'd1);
        s_valid = 1'b1;
        s_real  = 20'h11111;
        s_imag  = 20'h22222;
        step();
        chk("simul x_real", 64'(cic_x_real), 64'h11111);
        chk("simul x_imag", 64'(cic_x_imag), 64'h22222);
        chk("simul underflow", 64'(underflow), 64'd0);
        chk("simul ucnt", 64'(underflow_cnt), 64'd0);
        chk("simul s_ready", 64'(s_ready), 64'd1);
        cic_req = 1'b0;
        s_real  = 20'h33333;
        s_imag  = 20'h44444;
        step();
        chk("fetch2 x_real", 64'(cic_x_real), 64'h33333);
        chk("fetch2 s_ready", 64'(s_ready), 64'd0);

        // Underflow: two requests 10 clocks apart, no valid data.
        s_valid = 1'b0;
        uf_cnt  = 0;
        for (int i = 0; i < 12; i++) begin
            cic_req = (i == 0) || (i == 10);
            step();
            if (underflow) uf_cnt++;
            if (i == 10) begin
                held = ZF ? 20'h0 : 20'h33333;
                chk("uf pulse", 64'(underflow), 64'd1);
                chk("uf ucnt", 64'(underflow_cnt), 64'd1);
                chk("uf x_real", 64'(cic_x_real), 64'(held));
                chk("uf x_imag", 64'(cic_x_imag),
                    ZF ? 64'h0 : 64'h44444);
            end
        end
        chk("uf pulses", 64'(uf_cnt), 64'd1);
        chk("uf ucnt after", 64'(underflow_cnt), 64'd1);
        s_valid = 1'b1;
        s_real  = 20'h00ABC;
        s_imag  = 20'h00ABC;
        step();
        chk("refill x_real", 64'(cic_x_real), 64'h00ABC);
        chk("refill x_imag", 64'(cic_x_imag), 64'h00ABC);
        chk("refill s_ready", 64'(s_ready), 64'd0);

        // Saturation at 3, then reset in the middle of FETCH.
        s_valid = 1'b0;
        cic_req = 1'b1;
        step();
        chk("sat enter", 64'(underflow_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("sat[%0d]", i), 64'(underflow_cnt),
                (i == 0) ? 64'd2 : 64'd3);
        end
        reset = 1'b1;
        step();
        chk("mid rst s_ready", 64'(s_ready), 64'd0);
        chk("mid rst clock_en", 64'(cic_clock_en), 64'd0);
        chk("mid rst underflow", 64'(underflow), 64'd0);
        chk("mid rst ucnt", 64'(underflow_cnt), 64'd0);
        chk("mid rst running", 64'(running), 64'd0);
        chk("mid rst x_real", 64'(cic_x_real), 64'd0);

        // Disable during FETCH, then re-enable through PRIME.
        reset    = 1'b0;
        cic_req  = 1'b0;
        rate_inc = 32'hFFFF_FFFF;
        step();
        chk("dis prime", 64'(s_ready), 64'd1);
        s_valid = 1'b1;
        s_real  = 20'h0F0F0;
        s_imag  = 20'h0A0A0;
        step();
        chk("dis load", 64'(cic_x_real), 64'h0F0F0);
        s_valid = 1'b0;
        cic_req = 1'b1;
        step();
        step();
        held = ZF ? 20'h0 : 20'h0F0F0;
        chk("dis uf", 64'(underflow), 64'd1);
        chk("dis uf ce", 64'(cic_clock_en), 64'd1);
        cic_req = 1'b0;
        step();
        chk("dis pre ce", 64'(cic_clock_en), 64'd1);
        chk("dis pre ready", 64'(s_ready), 64'd1);
        enable = 1'b0;
        step();
        chk("dis s_ready", 64'(s_ready), 64'd0);
        chk("dis clock_en", 64'(cic_clock_en), 64'd0);
        chk("dis running", 64'(running), 64'd0);
        chk("dis x_real", 64'(cic_x_real), 64'(held));
        chk("dis ucnt", 64'(underflow_cnt), 64'd1);
        enable = 1'b1;
        step();
        chk("reen prime ready", 64'(s_ready), 64'd1);
        chk("reen prime run", 64'(running), 64'd0);
        step();
        chk("reen no strobe", 64'(cic_clock_en), 64'd0);
        s_valid = 1'b1;
        s_real  = 20'h0ABCD;
        step();
        chk("reen x_real", 64'(cic_x_real), 64'h0ABCD);
        chk("reen running", 64'(running), 64'd1);
        chk("reen ucnt", 64'(underflow_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
